led_pattern_sequencer: RTL and testbench

Autonomous Avalon-MM write master that drives the 8-bit LED PIO data register (offset 0) with a time-stepped pattern. Sits between a small control interface (enable/mode/period, from switches or a CPU-side register) and the LED PIO slave, so LEDs animate without CPU involvement. Generates one single-beat write per step, honours waitrequest, and clears the LEDs on disable.

---
 rtl/led_pattern_sequencer.sv | 135 +++++++++++++
 tb/tb_led_pattern_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// Autonomous Avalon-MM write master that animates the LED PIO data register.
// One single-beat write per step, waitrequest honoured, LEDs cleared on disable.
module led_pattern_sequencer #(
  parameter int PERIOD_W = 24,
  parameter int LED_W    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [PERIOD_W-1:0] period,
  output logic [1:0]          avm_address,
  output logic                avm_chipselect,
  output logic                avm_write_n,
  output logic [31:0]         avm_writedata,
  input  logic                avm_waitrequest,
  output logic [LED_W-1:0]    pattern,
  output logic                busy
);

  localparam logic [1:0] MODE_ROTATE = 2'd0;
  localparam logic [1:0] MODE_BOUNCE = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE, S_CLEAR} state_t;

  state_t               state_q, state_n;
  logic [PERIOD_W-1:0]  cnt_q, cnt_n;
  logic [LED_W-1:0]     pattern_q, pattern_n;
  logic                 dir_left_q, dir_left_n;
  logic [1:0]           mode_q, mode_n;
  logic [PERIOD_W-1:0]  per_last;
  logic                 step_due;

  function automatic logic [LED_W-1:0] seed_of(input logic [1:0] m);
    seed_of = (m == MODE_BLINK) ? {LED_W{1'b1}} : LED_W'(1);
  endfunction

  function automatic logic [LED_W-1:0] next_of(input logic [1:0] m,
                                               input logic [LED_W-1:0] p,
                                               input logic left);
    case (m)
      MODE_ROTATE: next_of = {p[LED_W-2:0], p[LED_W-1]};
      MODE_BOUNCE: begin
        // Reverse on the step after the lit bit reaches either end.
        if (left) next_of = p[LED_W-1] ? (p >> 1) : (p << 1);
        else      next_of = p[0]       ? (p << 1) : (p >> 1);
      end
      MODE_BLINK:  next_of = ~p;
      default:     next_of = p + LED_W'(1);
    endcase
  endfunction

  // Period 0 behaves as 1; >= lets a shortened period fire on the next cycle.
  assign per_last = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign step_due = (cnt_q >= per_last);

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    pattern_n  = pattern_q;
    dir_left_n = dir_left_q;
    mode_n     = mode_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          mode_n     = mode;
          pattern_n  = seed_of(mode);
          dir_left_n = 1'b1;
          cnt_n      = '0;
          state_n    = S_WRITE;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          pattern_n = '0;
          cnt_n     = '0;
          state_n   = S_CLEAR;
        end else if (step_due) begin
          cnt_n   = '0;
          state_n = S_WRITE;
          if (mode != mode_q) begin
            mode_n     = mode;
            pattern_n  = seed_of(mode);
            dir_left_n = 1'b1;
          end else begin
            pattern_n = next_of(mode_q, pattern_q, dir_left_q);
            if (mode_q == MODE_BOUNCE)
              dir_left_n = dir_left_q ? ~pattern_q[LED_W-1] : pattern_q[0];
          end
        end else begin
          cnt_n = cnt_q + PERIOD_W'(1);
        end
      end
      S_WRITE: begin
        if (!avm_waitrequest) begin
          if (enable) begin
            state_n = S_WAIT;
          end else begin
            pattern_n = '0;
            state_n   = S_CLEAR;
          end
        end
      end
      default: begin
        if (!avm_waitrequest) state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pattern_q  <= '0;
      dir_left_q <= 1'b1;
      mode_q     <= 2'd0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      pattern_q  <= pattern_n;
      dir_left_q <= dir_left_n;
      mode_q     <= mode_n;
    end
  end

  // Bus strobes decode straight from the state register so reset drops them at once.
  assign avm_chipselect = (state_q == S_WRITE) || (state_q == S_CLEAR);
  assign avm_write_n    = ~avm_chipselect;
  assign avm_address    = 2'd0;
  assign avm_writedata  = avm_chipselect ? {{(32-LED_W){1'b0}}, pattern_q} : 32'd0;
  assign pattern        = pattern_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomized self-checking bench for led_pattern_sequencer with a step-index pattern model.
module tb_led_pattern_sequencer;
  localparam int PW = 24;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [1:0]    mode;
  logic [PW-1:0] period;
  logic [1:0]    avm_address;
  logic          avm_chipselect;
  logic          avm_write_n;
  logic [31:0]   avm_writedata;
  logic          avm_waitrequest;
  logic [LW-1:0] pattern;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int proto_bad = 0;
  logic [7:0] wq_data[$];
  int         wq_cyc[$];

  led_pattern_sequencer #(.PERIOD_W(PW), .LED_W(LW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .period(period),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .pattern(pattern), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted write and watch the bus encoding on every cycle.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (avm_chipselect === 1'b1 && avm_waitrequest === 1'b0) begin
        wq_data.push_back(avm_writedata[7:0]);
        wq_cyc.push_back(cyc);
      end
      if (avm_write_n !== ~avm_chipselect || avm_address !== 2'd0 ||
          avm_writedata[31:8] !== 24'd0 ||
          (avm_chipselect === 1'b1 && avm_writedata[7:0] !== pattern))
        proto_bad++;
    end
  end

  // Pattern issued at step k after a fresh start in mode m.
  function automatic logic [7:0] exp_pat(input int m, input int k);
    int pos;
    case (m)
      0: exp_pat = 8'(1 << (k % 8));
      1: begin
        pos = k % 14;
        exp_pat = (pos < 8) ? 8'(1 << pos) : 8'(1 << (14 - pos));
      end
      2: exp_pat = (k % 2 == 0) ? 8'hFF : 8'h00;
      default: exp_pat = 8'((k + 1) % 256);
    endcase
  endfunction

  task automatic start_seq(input int m, input int p);
    wq_data.delete();
    wq_cyc.delete();
    mode   = 2'(m);
    period = PW'(p);
    enable = 1'b1;
  endtask

  task automatic wait_writes(input int n, input int budget, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (wq_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
      if (rnd) avm_waitrequest = ($urandom_range(0, 2) == 0);
    end
    avm_waitrequest = 1'b0;
  endtask

  task automatic stop_seq(output bit ok);
    enable = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (avm_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs got %0b want 0", avm_chipselect); end
    checks++; if (avm_write_n !== 1'b1) begin errors++; $display("FAIL reset_write_n got %0b want 1", avm_write_n); end
    checks++; if (avm_address !== 2'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", avm_address); end
    checks++; if (avm_writedata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", avm_writedata); end
    checks++; if (pattern !== 8'd0) begin errors++; $display("FAIL reset_pattern got %h want 0", pattern); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || wq_data.size() != 0) begin errors++; $display("FAIL idle_after_reset busy %0b writes %0d want 0 0", busy, wq_data.size()); end
  endtask

  task automatic run_fixed(input string nm, input int m, input int p, input int n);
    bit ok;
    int sp;
    sp = ((p == 0) ? 1 : p) + 1;
    @(posedge clk); #1;
    start_seq(m, p);
    wait_writes(n, n * (sp + 2) + 20, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_timeout got %0d writes want %0d", nm, wq_data.size(), n); end
    for (int k = 0; k < n && k < wq_data.size(); k++) begin
      checks++; if (wq_data[k] !== exp_pat(m, k)) begin errors++; $display("FAIL %s_data[%0d] got %h want %h", nm, k, wq_data[k], exp_pat(m, k)); end
      if (k > 0) begin
        checks++; if (wq_cyc[k] - wq_cyc[k-1] != sp) begin errors++; $display("FAIL %s_spacing[%0d] got %0d want %0d", nm, k, wq_cyc[k] - wq_cyc[k-1], sp); end
      end
    end
    stop_seq(ok);
    checks++; if (!ok || pattern !== 8'd0) begin errors++; $display("FAIL %s_stop busy_fell %0b pattern %h want 1 00", nm, ok, pattern); end
    checks++; if (wq_data.size() == 0 || wq_data[wq_data.size()-1] !== 8'h00) begin errors++; $display("FAIL %s_clear_write got %0d writes, last not 00", nm, wq_data.size()); end
  endtask

  task automatic test_modes();
    run_fixed("rotate", 0, 4, 10);
    run_fixed("bounce", 1, 1, 16);
    run_fixed("blink", 2, 1, 3);
    run_fixed("count", 3, 1, 257);
  endtask

  task automatic test_stall();
    bit ok;
    @(posedge clk); #1;
    avm_waitrequest = 1'b1;
    start_seq(0, 4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (avm_chipselect === 1'b1) break;
    end
    for (int s = 0; s < 4; s++) begin
      if (s > 0) begin @(negedge clk); #1; end
      checks++; if (avm_chipselect !== 1'b1 || avm_writedata !== 32'h1) begin errors++; $display("FAIL stall_hold[%0d] cs %0b data %h want 1 00000001", s, avm_chipselect, avm_writedata); end
      if (s == 2) begin @(posedge clk); #1; avm_waitrequest = 1'b0; end
    end
    checks++; if (wq_data.size() != 1) begin errors++; $display("FAIL stall_single got %0d writes want 1", wq_data.size()); end
    wait_writes(2, 40, 1'b0, ok);
    checks++; if (!ok || wq_data[1] !== 8'h02 || wq_cyc[1] - wq_cyc[0] != 5) begin errors++; $display("FAIL stall_next got ok %0b want 02 at spacing 5", ok); end
    stop_seq(ok);
  endtask

  task automatic test_disable_mid_write();
    bit ok;
    @(posedge clk); #1;
    start_seq(0, 3);
    wait_writes(3, 60, 1'b0, ok);
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (avm_chipselect === 1'b1) break;
    end
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    avm_waitrequest = 1'b0;
    stop_seq(ok);
    checks++; if (!ok || wq_data.size() != 5) begin errors++; $display("FAIL dis_count got %0d writes want 5", wq_data.size()); end
    checks++; if (wq_data.size() < 5 || wq_data[3] !== 8'h08 || wq_data[4] !== 8'h00) begin errors++; $display("FAIL dis_data got %0d writes want ... 08 00", wq_data.size()); end
    checks++; if (pattern !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL dis_final pattern %h busy %0b want 00 0", pattern, busy); end
  endtask

  task automatic test_period0_mode_change();
    bit ok;
    @(posedge clk); #1;
    start_seq(0, 0);
    wait_writes(4, 40, 1'b0, ok);
    for (int k = 1; k < 4; k++) begin
      checks++; if (wq_data[k] !== exp_pat(0, k) || wq_cyc[k] - wq_cyc[k-1] != 2) begin errors++; $display("FAIL p0[%0d] got %h gap %0d want %h gap 2", k, wq_data[k], wq_cyc[k] - wq_cyc[k-1], exp_pat(0, k)); end
    end
    mode = 2'd3;
    wait_writes(6, 40, 1'b0, ok);
    checks++; if (!ok || wq_data[4] !== 8'h01 || wq_data[5] !== 8'h02) begin errors++; $display("FAIL mode_change got ok %0b want 01 02 after switch", ok); end
    stop_seq(ok);
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    @(posedge clk); #1;
    avm_waitrequest = 1'b1;
    start_seq(0, 2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (avm_chipselect === 1'b1) break;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1) begin errors++; $display("FAIL async_rst_bus cs %0b wn %0b want 0 1", avm_chipselect, avm_write_n); end
    checks++; if (pattern !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL async_rst_state pattern %h busy %0b want 00 0", pattern, busy); end
    @(posedge clk); #1;
    enable = 1'b0;
    avm_waitrequest = 1'b0;
    reset_n = 1'b1;
    wq_data.delete();
    wq_cyc.delete();
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || wq_data.size() != 0) begin errors++; $display("FAIL rst_idle busy %0b writes %0d want 0 0", busy, wq_data.size()); end
    @(posedge clk); #1;
    start_seq(0, 2);
    wait_writes(1, 20, 1'b0, ok);
    checks++; if (!ok || wq_data[0] !== 8'h01) begin errors++; $display("FAIL rst_restart got ok %0b want seed 01", ok); end
    stop_seq(ok);
  endtask

  task automatic test_random();
    bit ok;
    int m, p;
    bit rnd;
    for (int r = 0; r < 6; r++) begin
      m = $urandom_range(0, 3);
      p = $urandom_range(0, 5);
      rnd = r[0];
      @(posedge clk); #1;
      start_seq(m, p);
      wait_writes(12, 400, rnd, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout got %0d writes want 12", r, wq_data.size()); end
      for (int k = 0; k < 12 && k < wq_data.size(); k++) begin
        checks++; if (wq_data[k] !== exp_pat(m, k)) begin errors++; $display("FAIL rand%0d_m%0d_data[%0d] got %h want %h", r, m, k, wq_data[k], exp_pat(m, k)); end
        if (!rnd && k > 0) begin
          checks++; if (wq_cyc[k] - wq_cyc[k-1] != ((p == 0) ? 1 : p) + 1) begin errors++; $display("FAIL rand%0d_gap[%0d] got %0d want %0d", r, k, wq_cyc[k] - wq_cyc[k-1], ((p == 0) ? 1 : p) + 1); end
        end
      end
      stop_seq(ok);
      checks++; if (!ok || pattern !== 8'h00) begin errors++; $display("FAIL rand%0d_stop busy_fell %0b pattern %h want 1 00", r, ok, pattern); end
    end
  endtask

  task automatic test_protocol();
    checks++; if (proto_bad != 0) begin errors++; $display("FAIL bus_encoding got %0d bad cycles want 0", proto_bad); end
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    mode = 2'd0;
    period = PW'(4);
    avm_waitrequest = 1'b0;
    test_reset();
    test_modes();
    test_stall();
    test_disable_mid_write();
    test_period0_mode_change();
    test_reset_mid_write();
    test_random();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
